// File: rtl/cmp_arb_pkg.sv
// Shared types for the EX comparator arbiter: branch funct3 encodings,
// arbiter FSM states and the invalid-op detector.
package cmp_arb_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    // cmpop[2:1] == 2'b01 is not a branch encoding.
    localparam logic [1:0] CMP_INVALID_MASK = 2'b01;

    function automatic logic cmp_op_invalid(input logic [2:0] op);
        return (op[2:1] == CMP_INVALID_MASK);
    endfunction

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// Branch / set-less-than comparator. Combinational; the arbiter registers
// its outputs.
module cmp
    import cmp_arb_pkg::*;
(
    input  logic [2:0]  i_cmpop,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_result,
    output logic        o_err
);

    logic w_base;

    always_comb begin
        w_base   = 1'b0;
        o_err    = cmp_op_invalid(i_cmpop);
        case (i_cmpop)
            BEQ, BNE:   w_base = (i_a == i_b);
            BLT, BGE:   w_base = ($signed(i_a) < $signed(i_b));
            BLTU, BGEU: w_base = (i_a < i_b);
            default:    w_base = 1'b0;
        endcase
        // ne/ge/geu are the inverted forms of eq/lt/ltu.
        o_result = o_err ? 1'b0 : (w_base ^ i_cmpop[0]);
    end

endmodule

// File: rtl/cmp_arbiter_rr_pick.sv
// One-hot request picker: round-robin starting at i_ptr, or fixed priority
// (lowest index wins) when i_fixed is set.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    input  logic               i_fixed,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Candidate k positions after the pointer, wrapping at NUM_REQ.
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PW+1)'(NUM_REQ);
            end
            w_idx = i_fixed ? PW'(k) : w_sum[PW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares the single branch/slt comparator between NUM_REQ requesters and
// holds one registered result per cycle with per-requester backpressure.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [3*NUM_REQ-1:0]  req_cmpop,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic                  resp_cmp,
    output logic                  resp_err,
    output arb_state_t            o_dbg_state
);

    // Handshake: a request transfers on a cycle where req_valid[i] and
    // req_ready[i] are both high; a result transfers when resp_valid[o] and
    // resp_ready[o] are both high. Requesters must not derive req_valid from
    // req_ready; resp_valid/resp_cmp/resp_err hold steady until transfer.

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic               r_resp_cmp;
    logic               r_resp_err;

    logic               w_slot_free;
    logic [NUM_REQ-1:0] w_req_masked;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any;
    logic [PW-1:0]      w_gidx;
    logic [PW-1:0]      w_ptr_nxt;
    logic [2:0]         w_sel_op;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_cmp;
    logic               w_err;

    // The slot frees up in the same cycle the owner consumes its result.
    assign w_slot_free  = (r_state == IDLE) || resp_ready[r_owner];
    assign w_req_masked = req_valid & {NUM_REQ{w_slot_free & rst_n}};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .i_req   (w_req_masked),
        .i_ptr   (r_ptr),
        .i_fixed (PRIO_MODE == 1),
        .o_grant (w_grant)
    );

    assign w_any     = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_gidx   = '0;
        w_sel_op = req_cmpop[2:0];
        w_sel_a  = req_a[31:0];
        w_sel_b  = req_b[31:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx   = PW'(i);
                w_sel_op = req_cmpop[i*3 +: 3];
                w_sel_a  = req_a[i*32 +: 32];
                w_sel_b  = req_b[i*32 +: 32];
            end
        end
    end

    // Next search starts one past the requester just granted.
    assign w_ptr_nxt = (w_gidx == PW'(NUM_REQ-1)) ? '0 : (w_gidx + PW'(1));

    cmp u_cmp (
        .i_cmpop  (w_sel_op),
        .i_a      (w_sel_a),
        .i_b      (w_sel_b),
        .o_result (w_cmp),
        .o_err    (w_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_resp_valid <= '0;
            r_resp_cmp   <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_any) begin
                r_ptr <= w_ptr_nxt;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state      <= RESP;
                        r_owner      <= w_gidx;
                        r_resp_valid <= w_grant;
                        r_resp_cmp   <= w_cmp;
                        r_resp_err   <= w_err;
                    end
                end
                RESP: begin
                    if (w_slot_free) begin
                        if (w_any) begin
                            r_owner      <= w_gidx;
                            r_resp_valid <= w_grant;
                            r_resp_cmp   <= w_cmp;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state      <= IDLE;
                            r_resp_valid <= '0;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= '0;
                end
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_cmp    = r_resp_cmp;
    assign resp_err    = r_resp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; a negedge monitor checks results and status.
module tb_cmp_arbiter;
    import cmp_arb_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic         dut;
        logic [N-1:0] rdy;
        logic [N-1:0] vld;
        logic         cmp;
        logic         err;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     resp_ready;
    logic [3*N-1:0]   req_cmpop;
    logic [32*N-1:0]  req_a;
    logic [32*N-1:0]  req_b;

    logic [N-1:0] d0_rdy, d0_vld, d1_rdy, d1_vld;
    logic         d0_cmp, d0_err, d1_cmp, d1_err;
    arb_state_t   d0_st, d1_st;

    logic [N+1:0] exp_q0[$];
    logic [N+1:0] exp_q1[$];
    chk_t         sq[$];
    logic [N+1:0] e;
    chk_t         s;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    cmp_arbiter #(.NUM_REQ(N), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d0_rdy),
        .req_cmpop(req_cmpop), .req_a(req_a), .req_b(req_b),
        .resp_valid(d0_vld), .resp_ready(resp_ready),
        .resp_cmp(d0_cmp), .resp_err(d0_err), .o_dbg_state(d0_st)
    );

    cmp_arbiter #(.NUM_REQ(N), .PRIO_MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d1_rdy),
        .req_cmpop(req_cmpop), .req_a(req_a), .req_b(req_b),
        .resp_valid(d1_vld), .resp_ready(resp_ready),
        .resp_cmp(d1_cmp), .resp_err(d1_err), .o_dbg_state(d1_st)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_cmpop[i*3 +: 3] = op;
        req_a[i*32 +: 32]   = a;
        req_b[i*32 +: 32]   = b;
    endtask

    task automatic exp_resp(input logic [N+1:0] e_rr, input logic [N+1:0] e_fx);
        exp_q0.push_back(e_rr);
        exp_q1.push_back(e_fx);
    endtask

    task automatic exp_stat(input logic d, input logic [N-1:0] rdy,
                            input logic [N-1:0] vld, input logic c, input logic er);
        chk_t t;
        t.dut = d; t.rdy = rdy; t.vld = vld; t.cmp = c; t.err = er;
        sq.push_back(t);
    endtask

    task automatic exp_stat2(input logic [N-1:0] rdy, input logic [N-1:0] vld,
                             input logic c, input logic er);
        exp_stat(1'b0, rdy, vld, c, er);
        exp_stat(1'b1, rdy, vld, c, er);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input int d,
                         input logic [5:0] got, input logic [5:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%b expected=%b (t=%0t)", name, d, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (|(d0_vld & resp_ready)) begin
            if (exp_q0.size() == 0) begin
                check("resp_unexpected", 0, {2'b00, d0_vld, d0_cmp, d0_err}, 6'd0);
            end else begin
                e = exp_q0.pop_front();
                check("resp", 0, {2'b00, d0_vld, d0_cmp, d0_err}, {2'b00, e});
            end
        end
        if (|(d1_vld & resp_ready)) begin
            if (exp_q1.size() == 0) begin
                check("resp_unexpected", 1, {2'b00, d1_vld, d1_cmp, d1_err}, 6'd0);
            end else begin
                e = exp_q1.pop_front();
                check("resp", 1, {2'b00, d1_vld, d1_cmp, d1_err}, {2'b00, e});
            end
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            if (s.dut == 1'b0)
                check("status", 0, {d0_rdy, d0_vld, d0_cmp, d0_err}, {s.rdy, s.vld, s.cmp, s.err});
            else
                check("status", 1, {d1_rdy, d1_vld, d1_cmp, d1_err}, {s.rdy, s.vld, s.cmp, s.err});
        end
        if (done) begin
            check("drain", 0, 6'(exp_q0.size()), 6'd0);
            check("drain", 1, 6'(exp_q1.size()), 6'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        req_cmpop  = '0;
        req_a      = '0;
        req_b      = '0;
        set_req(0, 3'b000, 32'd1, 32'd1);          // eq -> 1
        set_req(1, 3'b101, 32'hFFFF_FFFF, 32'd0);  // -1 >= 0 signed -> 0

        // Reset held with both requesters valid: nothing may be granted.
        repeat (2) begin
            step();
            exp_stat2(2'b00, 2'b00, 1'b0, 1'b0);
        end
        step();
        rst_n = 1'b1;

        // First grant after reset goes to requester 0 in both modes.
        exp_stat2(2'b01, 2'b00, 1'b0, 1'b0);
        exp_resp(4'b01_1_0, 4'b01_1_0);

        // Contention: round-robin alternates, fixed priority keeps req0.
        for (int i = 1; i < 4; i++) begin
            step();
            if (i == 1) begin
                exp_stat(1'b0, 2'b10, 2'b01, 1'b1, 1'b0);
                exp_stat(1'b1, 2'b01, 2'b01, 1'b1, 1'b0);
            end
            exp_resp((i % 2 == 1) ? 4'b10_0_0 : 4'b01_1_0, 4'b01_1_0);
        end
        step();
        req_valid = 2'b00;

        // Single requests: signed vs unsigned view of 0xFFFFFFFF < 1.
        step();
        set_req(0, 3'b100, 32'hFFFF_FFFF, 32'd1);
        req_valid = 2'b01;
        exp_resp(4'b01_1_0, 4'b01_1_0);
        step();
        set_req(0, 3'b110, 32'hFFFF_FFFF, 32'd1);
        exp_resp(4'b01_0_0, 4'b01_0_0);
        step();
        req_valid = 2'b00;

        // Backpressure on requester 1; resp_ready[0] must be ignored.
        step();
        set_req(1, 3'b000, 32'd5, 32'd5);
        req_valid  = 2'b10;
        resp_ready = 2'b01;
        exp_resp(4'b10_1_0, 4'b10_1_0);
        step();
        set_req(0, 3'b111, 32'd7, 32'd7);          // 7 >=u 7 -> 1
        req_valid = 2'b01;
        exp_stat2(2'b00, 2'b10, 1'b1, 1'b0);
        repeat (2) begin
            step();
            exp_stat2(2'b00, 2'b10, 1'b1, 1'b0);
        end
        step();
        resp_ready = 2'b10;
        exp_stat2(2'b01, 2'b10, 1'b1, 1'b0);
        exp_resp(4'b01_1_0, 4'b01_1_0);
        step();
        req_valid  = 2'b00;
        resp_ready = 2'b11;

        // Invalid op then a back-to-back valid one from the same requester.
        step();
        set_req(1, 3'b011, 32'd0, 32'd0);
        req_valid = 2'b10;
        exp_resp(4'b10_0_1, 4'b10_0_1);
        step();
        set_req(1, 3'b001, 32'd3, 32'd4);
        exp_resp(4'b10_1_0, 4'b10_1_0);
        step();
        req_valid = 2'b00;

        // Reset while a result is held: it disappears without a transfer.
        step();
        set_req(1, 3'b000, 32'd2, 32'd2);
        req_valid  = 2'b10;
        resp_ready = 2'b00;
        step();
        req_valid = 2'b00;
        exp_stat2(2'b00, 2'b10, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_stat2(2'b00, 2'b00, 1'b0, 1'b0);

        // Pointer is back at requester 0 after reset.
        step();
        set_req(0, 3'b000, 32'd9, 32'd9);
        set_req(1, 3'b001, 32'd9, 32'd9);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        exp_stat2(2'b01, 2'b00, 1'b0, 1'b0);
        exp_resp(4'b01_1_0, 4'b01_1_0);
        step();
        req_valid = 2'b00;
        repeat (2) step();
        done = 1'b1;
    end

endmodule
